// File: rtl/rgb565_hsv_pipe_if.sv
// Pixel-in / HSV-out signal bundle for rgb565_hsv_pipe; frame statistics
// signals exist only when HSV_FRAMESTAT_EN is defined.
interface rgb565_hsv_pipe_if #(
  parameter int COORD_W = 10
);
  logic               in_valid;
  logic [15:0]        in_rgb;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic               out_valid;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [9:0]         h_out;
  logic [6:0]         s_out;
  logic [6:0]         v_out;
`ifdef HSV_FRAMESTAT_EN
  logic               frame_start;
  logic [18:0]        dark_cnt;
`endif

  modport master (
    output in_valid, in_rgb, in_x, in_y,
`ifdef HSV_FRAMESTAT_EN
    output frame_start,
    input  dark_cnt,
`endif
    input  out_valid, out_x, out_y, h_out, s_out, v_out
  );

  modport slave (
    input  in_valid, in_rgb, in_x, in_y,
`ifdef HSV_FRAMESTAT_EN
    input  frame_start,
    output dark_cnt,
`endif
    output out_valid, out_x, out_y, h_out, s_out, v_out
  );
endinterface

// File: rtl/rgb565_hsv_pipe.sv
// Streaming RGB565 -> HSV converter, one pixel per clock, latency 3 (4 with OUT_REG=1), no stalls.
// Optional dark-pixel frame statistics enabled by defining HSV_FRAMESTAT_EN.
module rgb565_hsv_pipe #(
  parameter int COORD_W = 10,
  parameter int OUT_REG = 0
) (
  input logic             clk,
  input logic             reset,
  rgb565_hsv_pipe_if.slave px
);

  typedef enum logic [1:0] {SEC_R = 2'd0, SEC_G = 2'd1, SEC_B = 2'd2} sector_t;

  // ceil(65536/d); d=1 kept exact so every product stays bit-exact
  function automatic logic [16:0] recip(input logic [5:0] d);
    logic [16:0] r;
    case (d)
      6'd1:  r = 17'd65536; 6'd2:  r = 17'd32768; 6'd3:  r = 17'd21846; 6'd4:  r = 17'd16384;
      6'd5:  r = 17'd13108; 6'd6:  r = 17'd10923; 6'd7:  r = 17'd9363;  6'd8:  r = 17'd8192;
      6'd9:  r = 17'd7282;  6'd10: r = 17'd6554;  6'd11: r = 17'd5958;  6'd12: r = 17'd5462;
      6'd13: r = 17'd5042;  6'd14: r = 17'd4682;  6'd15: r = 17'd4370;  6'd16: r = 17'd4096;
      6'd17: r = 17'd3856;  6'd18: r = 17'd3641;  6'd19: r = 17'd3450;  6'd20: r = 17'd3277;
      6'd21: r = 17'd3121;  6'd22: r = 17'd2979;  6'd23: r = 17'd2850;  6'd24: r = 17'd2731;
      6'd25: r = 17'd2622;  6'd26: r = 17'd2521;  6'd27: r = 17'd2428;  6'd28: r = 17'd2341;
      6'd29: r = 17'd2260;  6'd30: r = 17'd2185;  6'd31: r = 17'd2115;  6'd32: r = 17'd2048;
      6'd33: r = 17'd1986;  6'd34: r = 17'd1928;  6'd35: r = 17'd1873;  6'd36: r = 17'd1821;
      6'd37: r = 17'd1772;  6'd38: r = 17'd1725;  6'd39: r = 17'd1681;  6'd40: r = 17'd1639;
      6'd41: r = 17'd1599;  6'd42: r = 17'd1561;  6'd43: r = 17'd1525;  6'd44: r = 17'd1490;
      6'd45: r = 17'd1457;  6'd46: r = 17'd1425;  6'd47: r = 17'd1395;  6'd48: r = 17'd1366;
      6'd49: r = 17'd1338;  6'd50: r = 17'd1311;  6'd51: r = 17'd1286;  6'd52: r = 17'd1261;
      6'd53: r = 17'd1237;  6'd54: r = 17'd1214;  6'd55: r = 17'd1192;  6'd56: r = 17'd1171;
      6'd57: r = 17'd1150;  6'd58: r = 17'd1130;  6'd59: r = 17'd1111;  6'd60: r = 17'd1093;
      6'd61: r = 17'd1075;  6'd62: r = 17'd1058;  6'd63: r = 17'd1041;
      default: r = 17'd0;
    endcase
    return r;
  endfunction

  // ---------------- stage 1: channel expansion, max/min, sector ----------------
  logic [5:0] r6, g6, b6, mx, mn, da, db;
  sector_t    sec;

  always_comb begin
    r6 = {px.in_rgb[15:11], px.in_rgb[15]};
    g6 = px.in_rgb[10:5];
    b6 = {px.in_rgb[4:0], px.in_rgb[4]};
    mx = r6;
    if (g6 > mx) mx = g6;
    if (b6 > mx) mx = b6;
    mn = r6;
    if (g6 < mn) mn = g6;
    if (b6 < mn) mn = b6;
    if (r6 == mx) begin
      sec = SEC_R; da = g6; db = b6;
    end else if (g6 == mx) begin
      sec = SEC_G; da = b6; db = r6;
    end else begin
      sec = SEC_B; da = r6; db = g6;
    end
  end

  logic               s1_vld, s1_neg;
  logic [COORD_W-1:0] s1_x, s1_y;
  sector_t            s1_sec;
  logic [5:0]         s1_abs, s1_delta, s1_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_sec   <= SEC_R;
      s1_neg   <= 1'b0;
      s1_abs   <= '0;
      s1_delta <= '0;
      s1_max   <= '0;
    end else begin
      s1_vld   <= px.in_valid;
      s1_x     <= px.in_x;
      s1_y     <= px.in_y;
      s1_sec   <= sec;
      s1_neg   <= (da < db);
      s1_abs   <= (da < db) ? (db - da) : (da - db);
      s1_delta <= mx - mn;
      s1_max   <= mx;
    end
  end

  // ---------------- stage 2: reciprocal multiplies ----------------
  logic [30:0] prod_h, prod_s, prod_v;

  always_comb begin
    prod_h = 31'(s1_abs) * 31'(60) * 31'(recip(s1_delta));
    prod_s = 31'(s1_delta) * 31'(100) * 31'(recip(s1_max));
    prod_v = 31'(s1_max) * 31'(100) * 31'(recip(6'd63));
  end

  logic               s2_vld, s2_neg, s2_dz, s2_mz;
  logic [COORD_W-1:0] s2_x, s2_y;
  sector_t            s2_sec;
  logic [14:0]        s2_qh, s2_qs, s2_qv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld <= 1'b0;
      s2_x   <= '0;
      s2_y   <= '0;
      s2_sec <= SEC_R;
      s2_neg <= 1'b0;
      s2_dz  <= 1'b0;
      s2_mz  <= 1'b0;
      s2_qh  <= '0;
      s2_qs  <= '0;
      s2_qv  <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_x   <= s1_x;
      s2_y   <= s1_y;
      s2_sec <= s1_sec;
      s2_neg <= s1_neg;
      s2_dz  <= (s1_delta == 6'd0);
      s2_mz  <= (s1_max == 6'd0);
      s2_qh  <= 15'(prod_h >> 16);
      s2_qs  <= 15'(prod_s >> 16);
      s2_qv  <= 15'(prod_v >> 16);
    end
  end

  // ---------------- stage 3: hue assembly and clamping ----------------
  logic [15:0] base, h_sum;
  logic [9:0]  h_nxt;
  logic [6:0]  s_nxt, v_nxt;

  always_comb begin
    case (s2_sec)
      SEC_G:   base = 16'd120;
      SEC_B:   base = 16'd240;
      default: base = 16'd0;
    endcase
    // red sector wraps below 0 degrees, so it subtracts from 360
    if (s2_neg && s2_qh != 15'd0)
      h_sum = ((base == 16'd0) ? 16'd360 : base) - {1'b0, s2_qh};
    else
      h_sum = base + {1'b0, s2_qh};
    h_nxt = s2_dz ? 10'd0 : ((h_sum > 16'd359) ? 10'd359 : h_sum[9:0]);
    s_nxt = (s2_dz || s2_mz) ? 7'd0 : ((s2_qs > 15'd100) ? 7'd100 : s2_qs[6:0]);
    v_nxt = (s2_qv > 15'd100) ? 7'd100 : s2_qv[6:0];
  end

  logic               s3_vld;
  logic [COORD_W-1:0] s3_x, s3_y;
  logic [9:0]         s3_h;
  logic [6:0]         s3_s, s3_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_vld <= 1'b0;
      s3_x   <= '0;
      s3_y   <= '0;
      s3_h   <= '0;
      s3_s   <= '0;
      s3_v   <= '0;
    end else begin
      s3_vld <= s2_vld;
      s3_x   <= s2_x;
      s3_y   <= s2_y;
      s3_h   <= h_nxt;
      s3_s   <= s_nxt;
      s3_v   <= v_nxt;
    end
  end

  // ---------------- optional extra output register ----------------
  logic               o_vld;
  logic [COORD_W-1:0] o_x, o_y;
  logic [9:0]         o_h;
  logic [6:0]         o_s, o_v;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          o_vld <= 1'b0;
          o_x   <= '0;
          o_y   <= '0;
          o_h   <= '0;
          o_s   <= '0;
          o_v   <= '0;
        end else begin
          o_vld <= s3_vld;
          o_x   <= s3_x;
          o_y   <= s3_y;
          o_h   <= s3_h;
          o_s   <= s3_s;
          o_v   <= s3_v;
        end
      end
    end else begin : g_out_direct
      assign o_vld = s3_vld;
      assign o_x   = s3_x;
      assign o_y   = s3_y;
      assign o_h   = s3_h;
      assign o_s   = s3_s;
      assign o_v   = s3_v;
    end
  endgenerate

  assign px.out_valid = o_vld;
  assign px.out_x     = o_x;
  assign px.out_y     = o_y;
  assign px.h_out     = o_h;
  assign px.s_out     = o_s;
  assign px.v_out     = o_v;

`ifdef HSV_FRAMESTAT_EN
  logic [18:0] dark_acc, dark_q, dark_sum;

  // a dark pixel coinciding with frame_start belongs to the closing frame
  always_comb begin
    dark_sum = dark_acc;
    if (o_vld && (o_v < 7'd20) && (dark_acc != 19'h7FFFF))
      dark_sum = dark_acc + 19'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dark_acc <= '0;
      dark_q   <= '0;
    end else if (px.frame_start) begin
      dark_q   <= dark_sum;
      dark_acc <= '0;
    end else begin
      dark_acc <= dark_sum;
    end
  end

  assign px.dark_cnt = dark_q;
`endif

endmodule

// File: tb/tb_rgb565_hsv_pipe.sv
// Randomized self-checking bench for rgb565_hsv_pipe against an arithmetic HSV reference.
module tb_rgb565_hsv_pipe;
  localparam int CW      = 10;
  localparam int OUT_REG = 0;
  localparam int LAT     = 3 + OUT_REG;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rgb565_hsv_pipe_if #(.COORD_W(CW)) px();
  rgb565_hsv_pipe #(.COORD_W(CW), .OUT_REG(OUT_REG)) dut (
    .clk  (clk),
    .reset(reset),
    .px   (px)
  );

  typedef struct {
    bit vld;
    int x;
    int y;
    int h;
    int s;
    int v;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  function automatic int ceil_recip(input int d);
    return (d == 0) ? 0 : (65536 + d - 1) / d;
  endfunction

  // HSV from the arithmetic rules: 6-bit channels, reciprocal-based division
  function automatic exp_t model(input bit vld, input logic [15:0] rgb, input int x, input int y);
    exp_t e;
    int r, g, b, mx, mn, d, diff, base, qh, qs, qv, h, s, v;
    r = int'(rgb[15:11]) * 2 + int'(rgb[15]);
    g = int'(rgb[10:5]);
    b = int'(rgb[4:0]) * 2 + int'(rgb[4]);
    mx = (r > g) ? r : g;  mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;  mn = (b < mn) ? b : mn;
    d  = mx - mn;
    if (r == mx)      begin base = 0;   diff = g - b; end
    else if (g == mx) begin base = 120; diff = b - r; end
    else              begin base = 240; diff = r - g; end
    qh = (60 * (diff < 0 ? -diff : diff) * ceil_recip(d)) >>> 16;
    qs = (100 * d * ceil_recip(mx)) >>> 16;
    qv = (100 * mx * ceil_recip(63)) >>> 16;
    if (diff < 0 && qh > 0) h = ((base == 0) ? 360 : base) - qh;
    else                    h = base + qh;
    s = qs;
    v = qv;
    if (d == 0)  begin h = 0; s = 0; end
    if (mx == 0) s = 0;
    if (h > 359) h = 359;
    if (s > 100) s = 100;
    if (v > 100) v = 100;
    e.vld = vld; e.x = x; e.y = y; e.h = h; e.s = s; e.v = v;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [15:0] rgb, input int x, input int y);
    px.in_valid = v;
    px.in_rgb   = rgb;
    px.in_x     = CW'(x);
    px.in_y     = CW'(y);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 16'h0000, 0, 0);
`ifdef HSV_FRAMESTAT_EN
    px.frame_start = 1'b0;
`endif
    repeat (3) tick();
    checks++; if (px.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b expected 0", px.out_valid); end
    checks++; if (px.h_out !== 10'd0) begin errors++; $display("FAIL reset h_out got %0d expected 0", px.h_out); end
    checks++; if (px.s_out !== 7'd0) begin errors++; $display("FAIL reset s_out got %0d expected 0", px.s_out); end
    checks++; if (px.v_out !== 7'd0) begin errors++; $display("FAIL reset v_out got %0d expected 0", px.v_out); end
    checks++; if (px.out_x !== '0 || px.out_y !== '0) begin errors++; $display("FAIL reset xy got %0d/%0d expected 0/0", px.out_x, px.out_y); end
`ifdef HSV_FRAMESTAT_EN
    checks++; if (px.dark_cnt !== 19'd0) begin errors++; $display("FAIL reset dark_cnt got %0d expected 0", px.dark_cnt); end
`endif
    reset = 1'b0;
    repeat (2) tick();
  endtask

  // Directed colours with hand-derived H/S/V and exact latency
  task automatic test_primaries();
    logic [15:0] rgbs [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hF81F, 16'hFFFF, 16'h0000, 16'h07FF, 16'hFFE0};
    int hs [8] = '{0,   120, 240, 300, 0,   0, 180, 60};
    int ss [8] = '{100, 100, 100, 100, 0,   0, 100, 100};
    int vs [8] = '{100, 100, 100, 100, 100, 0, 100, 100};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rgbs[i], 5, 7);
      tick();
      drive(1'b0, 16'h0000, 0, 0);
      for (int k = 1; k < LAT; k++) begin
        checks++;
        if (px.out_valid !== 1'b0) begin errors++; $display("FAIL early_valid pix %0d edge %0d got %b expected 0", i, k, px.out_valid); end
        tick();
      end
      checks++; if (px.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid pix %0d got %b expected 1", i, px.out_valid); end
      checks++; if (px.out_x !== 10'd5 || px.out_y !== 10'd7) begin errors++; $display("FAIL prim_xy pix %0d got %0d/%0d expected 5/7", i, px.out_x, px.out_y); end
      checks++; if (px.h_out !== 10'(hs[i])) begin errors++; $display("FAIL prim_h pix %0d got %0d expected %0d", i, px.h_out, hs[i]); end
      checks++; if (px.s_out !== 7'(ss[i])) begin errors++; $display("FAIL prim_s pix %0d got %0d expected %0d", i, px.s_out, ss[i]); end
      checks++; if (px.v_out !== 7'(vs[i])) begin errors++; $display("FAIL prim_v pix %0d got %0d expected %0d", i, px.v_out, vs[i]); end
      tick();
    end
  endtask

  task automatic test_random_stream();
    exp_t e;
    bit v;
    logic [15:0] rgb;
    int y;
    q.delete();
    for (int i = 0; i < 640 + LAT; i++) begin
      v   = (i < 640) && (i % 3 != 2);
      rgb = 16'($urandom);
      y   = int'($urandom_range(0, 479));
      drive(v, rgb, i % 640, y);
      q.push_back(model(v, rgb, i % 640, y));
      tick();
      if (q.size() == LAT) begin
        e = q.pop_front();
        checks++;
        if (px.out_valid !== e.vld) begin errors++; $display("FAIL rs_valid cyc %0d got %b expected %b", i, px.out_valid, e.vld); end
        checks++;
        if (px.out_x !== CW'(e.x) || px.out_y !== CW'(e.y)) begin errors++; $display("FAIL rs_xy cyc %0d got %0d/%0d expected %0d/%0d", i, px.out_x, px.out_y, e.x, e.y); end
        if (e.vld) begin
          checks++;
          if (px.h_out !== 10'(e.h) || px.s_out !== 7'(e.s) || px.v_out !== 7'(e.v)) begin
            errors++;
            $display("FAIL rs_hsv cyc %0d got %0d/%0d/%0d expected %0d/%0d/%0d", i, px.h_out, px.s_out, px.v_out, e.h, e.s, e.v);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dir [6] = '{16'hF81F, 16'h07FF, 16'hFFE0, 16'h0821, 16'h8410, 16'h0001};
    exp_t e;
    logic [15:0] rgb;
    bit v;
    q.delete();
    for (int i = 0; i < 40 + LAT; i++) begin
      v   = (i < 40);
      rgb = (i < 6) ? dir[i] : 16'($urandom);
      drive(v, rgb, i, 100 + i);
      q.push_back(model(v, rgb, i, 100 + i));
      tick();
      if (q.size() == LAT) begin
        e = q.pop_front();
        checks++;
        if (px.out_valid !== e.vld || px.out_x !== CW'(e.x) || px.out_y !== CW'(e.y)) begin
          errors++;
          $display("FAIL b2b_side cyc %0d got %b %0d/%0d expected %b %0d/%0d", i, px.out_valid, px.out_x, px.out_y, e.vld, e.x, e.y);
        end
        if (e.vld) begin
          checks++;
          if (px.h_out !== 10'(e.h) || px.s_out !== 7'(e.s) || px.v_out !== 7'(e.v)) begin
            errors++;
            $display("FAIL b2b_hsv cyc %0d got %0d/%0d/%0d expected %0d/%0d/%0d", i, px.h_out, px.s_out, px.v_out, e.h, e.s, e.v);
          end
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    drive(1'b1, 16'hFFFF, 1, 1); tick();
    drive(1'b1, 16'hF800, 2, 2); tick();
    drive(1'b1, 16'h07E0, 3, 3); tick();
    drive(1'b0, 16'h0000, 0, 0);
    reset = 1'b1;
    #2;
    checks++; if (px.out_valid !== 1'b0) begin errors++; $display("FAIL rst_fly valid got %b expected 0", px.out_valid); end
    checks++; if (px.h_out !== 10'd0 || px.s_out !== 7'd0 || px.v_out !== 7'd0) begin errors++; $display("FAIL rst_fly hsv got %0d/%0d/%0d expected 0/0/0", px.h_out, px.s_out, px.v_out); end
    checks++; if (px.out_x !== '0 || px.out_y !== '0) begin errors++; $display("FAIL rst_fly xy got %0d/%0d expected 0/0", px.out_x, px.out_y); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      checks++;
      if (px.out_valid !== 1'b0 || px.v_out !== 7'd0) begin errors++; $display("FAIL rst_leak edge %0d got valid %b v %0d expected 0 0", k, px.out_valid, px.v_out); end
    end
  endtask

`ifdef HSV_FRAMESTAT_EN
  task automatic test_framestat();
    drive(1'b0, 16'h0000, 0, 0);
    px.frame_start = 1'b1;
    tick();
    px.frame_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(c < 10, 16'h0000, c, 0);
      px.frame_start = (c == 9 + LAT);
      tick();
      if (c == 9 + LAT) begin
        checks++;
        if (px.dark_cnt !== 19'd10) begin errors++; $display("FAIL dark_cnt frame1 got %0d expected 10", px.dark_cnt); end
      end
    end
    px.frame_start = 1'b0;
    for (int c = 0; c < 3 + LAT; c++) begin
      drive(c < 3, 16'h0000, c, 1);
      tick();
    end
    px.frame_start = 1'b1;
    tick();
    px.frame_start = 1'b0;
    checks++;
    if (px.dark_cnt !== 19'd3) begin errors++; $display("FAIL dark_cnt frame2 got %0d expected 3", px.dark_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_primaries();
    test_random_stream();
    test_back_to_back();
    test_reset_inflight();
`ifdef HSV_FRAMESTAT_EN
    test_framestat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb565_hsv_pipe.md
Name: rgb565_hsv_pipe

Overview:
- Streaming RGB565-to-HSV converter feeding the VGA memory controller's HSV inputs and its green-pixel detector.
- Takes the frame-buffer read pixel and its screen coordinates, and emits H/S/V plus delayed coordinates, all aligned to the same cycle.
- Accepts one pixel per clock, uses no stalls, and has a fixed latency.
- Division is replaced by a 64-entry reciprocal LUT, so the arithmetic model is bit-exact and cheap.

Parameters:
- COORD_W, 10, width of the x/y coordinate sideband.
- OUT_REG, 0, value 1 adds one output register stage: latency 3 becomes 4.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  pixel valid (driven from den)
- in_rgb  in  16  RGB565 pixel {R5,G6,B5}
- in_x  in  COORD_W  pixel x
- in_y  in  COORD_W  pixel y
- out_valid  out  1  in_valid delayed by the latency
- out_x  out  COORD_W  in_x delayed by the latency
- out_y  out  COORD_W  in_y delayed by the latency
- h_out  out  10  hue, 0..359 degrees
- s_out  out  7  saturation, 0..100
- v_out  out  7  value, 0..100
- dark_cnt  out  19  present only with HSV_FRAMESTAT_EN
- frame_start  in  1  present only with HSV_FRAMESTAT_EN

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. All pipeline registers and all outputs go to 0, including out_valid=0 and dark_cnt=0.
- Reset mid-stream discards all in-flight pixels. The first valid output appears at the full latency after the first post-reset in_valid.
- No handshake or backpressure. Every stage advances every clock, and x/y/valid travel with the data.
- Data registers load regardless of in_valid. When out_valid=0, the h/s/v contents are don't-care, but they must be deterministic (no X after reset).
- Stage 1: expand each channel to 6 bits.
  - R6={R5,R5[4]}, G6=G6, B6={B5,B5[4]}.
  - Compute max, min, and delta=max-min (6 bits).
  - Select sector with priority R>G>B on ties:
    - sector R if R6==max;
    - else sector G if G6==max;
    - else sector B.
  - Compute the signed difference diff:
    - sector R: G6-B6;
    - sector G: B6-R6;
    - sector B: R6-G6.
  - Register sign(diff) and |diff|.
- Reciprocal LUT: recip[d]=ceil(65536/d) for d=1..63, recip[0]=0, 11-bit entries (recip[1]=65536 saturates to 2047 and is never needed at d=1 for scale>=60 products because of the clamp below). Implemented as a case ROM.
  - Correction: recip[1] must be stored exactly, so entries are 17 bits.
- Stage 2: form the 17-bit products.
  - qh = (60*|diff|*recip[delta])>>16.
  - qs = (100*delta*recip[max])>>16.
  - qv = (100*max*recip[63])>>16.
  - Products are at most 31 bits. Truncation (floor) is the defined result.
- Stage 3: build the hue.
  - base is 0, 120 or 240 by sector.
  - If sign is negative and qh>0: h = base-qh, with base 0 treated as 360.
  - Otherwise: h = base+qh.
  - If delta==0: h=0 and s=0.
  - If max==0: s=0.
  - s and v are clamped to 100, h is clamped to 359.
  - Register the results to the outputs.
- With OUT_REG=1, all outputs including the sideband pass through one extra register stage.
- Back-to-back pixels need no bubbles. A change of in_valid mid-line propagates exactly with the data.

Optional Feature:
- Macro: HSV_FRAMESTAT_EN.
- When defined, adds the frame_start input and the dark_cnt output.
  - An internal 19-bit counter increments on each out_valid cycle with v_out<20, saturating at 2^19-1.
  - When frame_start=1, dark_cnt latches counter+(current-cycle increment) and the counter restarts at 0.
  - If frame_start coincides with a dark valid pixel, the pixel counts toward the closing frame.
  - dark_cnt resets to 0.
- When not defined, neither port exists, no counter logic is present, and the rest of the block is unchanged.

Test Plan:
- Reset, then in_rgb=16'hF800 with in_valid=1, x=5, y=7 -> 3 cycles later out_valid=1, h=0, s=100, v=100, x=5, y=7.
- 16'h07E0 -> h=120, s=100, v=100. 16'h001F -> h=240, s=100, v=100.
- 16'hF81F (magenta, R/B tie) -> sector R, qh=60, h=300, s=100, v=100. 16'hFFFF -> 0/0/100. 16'h0000 -> 0/0/0.
- Stream 640 random pixels with in_valid toggling every 3rd cycle -> outputs match the bit-exact LUT model each cycle, with out_valid and x/y delayed exactly 3 cycles (4 with OUT_REG=1).
- Assert reset for 1 cycle while 3 pixels are in flight -> out_valid=0 and all outputs 0 immediately; none of the in-flight pixels emerge.
- HSV_FRAMESTAT_EN: 10 valid black pixels then frame_start, where the 10th black pixel's out_valid coincides with frame_start -> dark_cnt=10, and the next frame starts counting from 0.
